// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Holds the FSM state encoding, requester IDs, the default busy-wait limit
// and the baud/sample divider constants used by the transmitter side.
package uart_pkg;

    // Arbiter FSM state encoding
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE      = 2'd0;
    localparam arb_state_t ST_START     = 2'd1;
    localparam arb_state_t ST_WAIT_BUSY = 2'd2;
    localparam arb_state_t ST_WAIT_DONE = 2'd3;

    // Requester IDs; also the bit index of each requester in req/gnt vectors
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    // Cycles allowed after tx_start for the transmitter to report busy
    localparam int WAIT_TO_DEFAULT = 16;

    // Baud-rate and oversample dividers of the serializer
    localparam int BAUD_DIV   = 5199;
    localparam int SAMPLE_DIV = 324;

endpackage

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// Two-way round-robin selector.
// Ports:
//   req  - request vector, bit REQ_CPU / bit REQ_DBG
//   last - requester served most recently
//   gnt  - one-hot grant (all zero when nothing requests)
// A sole requester always wins; on contention the requester that was not
// served last wins.
module rr_arb2
    import uart_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[REQ_CPU] && req[REQ_DBG]) begin
            if (last == REQ_DBG) begin
                gnt[REQ_CPU] = 1'b1;
            end else begin
                gnt[REQ_DBG] = 1'b1;
            end
        end else if (req[REQ_CPU]) begin
            gnt[REQ_CPU] = 1'b1;
        end else if (req[REQ_DBG]) begin
            gnt[REQ_DBG] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates CPU and debug-port byte requests onto one UART transmitter.
// Ports:
//   sysclk, reset          - clock, synchronous active-high reset
//   cpu_valid/data/ready   - CPU byte request; ready pulses on acceptance
//   dbg_valid/data/ready   - debug byte request; ready pulses on acceptance
//   tx_start, tx_data      - one-cycle launch pulse and registered byte
//   tx_busy                - busy indication from the serializer
//   grant_id               - owner of the current/last transfer (0 CPU, 1 debug)
//   err_timeout, err_clr   - sticky "transmitter never went busy" flag and clear
// Handshake: a requester holds valid (and data) until it sees ready high; a
// byte is accepted in the cycle valid && ready is true. ready is only ever
// high in IDLE, outside reset, and for at most one requester per cycle.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int WAIT_TO = WAIT_TO_DEFAULT
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       cpu_valid,
    input  logic [7:0] cpu_data,
    output logic       cpu_ready,
    input  logic       dbg_valid,
    input  logic [7:0] dbg_data,
    output logic       dbg_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       grant_id,
    output logic       err_timeout,
    input  logic       err_clr
);

    localparam int            CW       = $clog2(WAIT_TO) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TO - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    arb_state_t    state_q,    state_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [7:0]    tx_data_q,  tx_data_d;
    logic          grant_id_q, grant_id_d;
    logic          last_q,     last_d;
    logic          err_q,      err_d;
    logic [1:0]    gnt;
    logic          accept;
    logic          timeout;

    rr_arb2 u_rr_arb2 (
        .req  ({dbg_valid, cpu_valid}),
        .last (last_q),
        .gnt  (gnt)
    );

    // Reset gating keeps ready low in the cycle reset is applied, even
    // though the state register still shows IDLE.
    assign accept    = (state_q == ST_IDLE) && !reset && (cpu_valid || dbg_valid);
    assign cpu_ready = accept && gnt[REQ_CPU];
    assign dbg_ready = accept && gnt[REQ_DBG];

    assign timeout = (state_q == ST_WAIT_BUSY) && !tx_busy && (cnt_q >= CNT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tx_data_d  = gnt[REQ_DBG] ? dbg_data : cpu_data;
                    grant_id_d = gnt[REQ_DBG];
                    last_d     = gnt[REQ_DBG];
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                // tx_busy is deliberately not looked at here; WAIT_BUSY
                // picks it up on the following cycle.
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A timeout in the same cycle as err_clr keeps the flag set.
        if (timeout) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_data_q  <= 8'h00;
            grant_id_q <= REQ_CPU;
            last_q     <= REQ_DBG;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            err_q      <= err_d;
        end
    end

    assign tx_start    = (state_q == ST_START);
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural serializer model and
// a scoreboard of expected {grant_id, tx_data} pairs popped on each tx_start.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int WAIT_TO = 16;

    logic       sysclk    = 1'b0;
    logic       reset     = 1'b1;
    logic       cpu_valid = 1'b0;
    logic [7:0] cpu_data  = 8'h00;
    logic       cpu_ready;
    logic       dbg_valid = 1'b0;
    logic [7:0] dbg_data  = 8'h00;
    logic       dbg_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy   = 1'b0;
    logic       grant_id;
    logic       err_timeout;
    logic       err_clr   = 1'b0;

    int n_vec   = 0;
    int n_err   = 0;
    int n_start = 0;
    logic [8:0] exp_q[$];

    // Serializer model knobs: busy rises busy_delay cycles after tx_start
    // (0 = never) and stays high busy_len cycles.
    int busy_delay = 2;
    int busy_len   = 10;
    bit busy_kill  = 1'b0;
    int pend       = 0;
    int hold       = 0;

    always #5 sysclk = ~sysclk;

    uart_tx_arbiter #(.WAIT_TO(WAIT_TO)) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .cpu_valid   (cpu_valid),
        .cpu_data    (cpu_data),
        .cpu_ready   (cpu_ready),
        .dbg_valid   (dbg_valid),
        .dbg_data    (dbg_data),
        .dbg_ready   (dbg_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always @(posedge sysclk) begin
        if (busy_kill) begin
            pend = 0;
            hold = 0;
            tx_busy <= 1'b0;
        end else begin
            if (tx_busy && hold > 0) begin
                hold = hold - 1;
                if (hold == 0) tx_busy <= 1'b0;
            end
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    tx_busy <= 1'b1;
                    hold = busy_len;
                end
            end
            if (tx_start === 1'b1 && busy_delay > 0) begin
                if (busy_delay == 1) begin
                    tx_busy <= 1'b1;
                    hold = busy_len;
                end else begin
                    pend = busy_delay - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        logic [8:0] e;
        @(posedge sysclk);
        #1;
        if (tx_start === 1'b1) begin
            n_start++;
            if (exp_q.size() == 0) begin
                check("tx_start_unexpected", 32'(tx_start), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("tx_grant_data", {23'd0, grant_id, tx_data}, {23'd0, e});
            end
        end
    endtask

    task automatic wait_state(input logic [1:0] st, input int max, output int n);
        n = 0;
        while (dut.state_q !== st && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, grants, cyc, winner, last_acc, exp_last;

        // ---- reset, requests held high must not be acknowledged ----
        cpu_valid = 1'b1; cpu_data = 8'hEE;
        dbg_valid = 1'b1; dbg_data = 8'hDD;
        tick(); tick();
        check("ready_in_reset_cpu", 32'(cpu_ready), 32'd0);
        check("ready_in_reset_dbg", 32'(dbg_ready), 32'd0);
        cpu_valid = 1'b0; dbg_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("rst_state",    32'(dut.state_q), 32'(ST_IDLE));
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data",  32'(tx_data), 32'h00);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_err",      32'(err_timeout), 32'd0);
        exp_last = 1;

        // ---- both requesting continuously: round robin from CPU ----
        busy_delay = 2; busy_len = 3;
        cpu_data = 8'hA1; dbg_data = 8'hB2;
        cpu_valid = 1'b1; dbg_valid = 1'b1;
        #1;
        grants = 0; cyc = 0; last_acc = 0;
        while (grants < 4 && cyc < 200) begin
            check("never_both_ready", 32'(cpu_ready & dbg_ready), 32'd0);
            if (cpu_ready || dbg_ready) begin
                winner = (exp_last == 1) ? 0 : 1;
                check("rr_cpu_ready", 32'(cpu_ready), 32'(winner == 0));
                check("rr_dbg_ready", 32'(dbg_ready), 32'(winner == 1));
                if (grants > 0) check("accept_spacing_min4", 32'(cyc - last_acc >= 4), 32'd1);
                last_acc = cyc;
                exp_q.push_back(winner == 0 ? {1'b0, 8'hA1} : {1'b1, 8'hB2});
                exp_last = winner;
                grants++;
            end
            tick();
            cyc++;
        end
        cpu_valid = 1'b0; dbg_valid = 1'b0;
        check("rr_grant_count", 32'(grants), 32'd4);
        wait_state(ST_IDLE, 50, n);
        check("rr_back_to_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // ---- CPU alone, busy 2 cycles after start for 10 cycles ----
        busy_delay = 2; busy_len = 10;
        cpu_data = 8'h55; cpu_valid = 1'b1;
        #1;
        check("cpu_alone_ready", 32'(cpu_ready), 32'd1);
        check("cpu_alone_dbg_ready", 32'(dbg_ready), 32'd0);
        exp_q.push_back({1'b0, 8'h55});
        exp_last = 0;
        tick();
        check("start_pulse", 32'(tx_start), 32'd1);
        check("start_tx_data", 32'(tx_data), 32'h55);
        check("start_grant_id", 32'(grant_id), 32'd0);
        check("ready_low_in_start", 32'(cpu_ready), 32'd0);
        cpu_valid = 1'b0; cpu_data = 8'h00;
        tick();
        check("start_one_cycle", 32'(tx_start), 32'd0);
        check("tx_data_stable", 32'(tx_data), 32'h55);
        wait_state(ST_IDLE, 40, n);
        check("idle_after_busy_fall", 32'(n), 32'd12);
        check("tx_data_held_at_idle", 32'(tx_data), 32'h55);

        // ---- debug request arriving during WAIT_DONE ----
        busy_len = 6;
        cpu_data = 8'h6A; cpu_valid = 1'b1;
        #1;
        check("c_cpu_ready", 32'(cpu_ready), 32'd1);
        exp_q.push_back({1'b0, 8'h6A});
        exp_last = 0;
        tick();
        cpu_valid = 1'b0;
        wait_state(ST_WAIT_DONE, 20, n);
        check("c_reach_wait_done", 32'(dut.state_q), 32'(ST_WAIT_DONE));
        dbg_data = 8'h3C; dbg_valid = 1'b1;
        #1;
        cyc = 0;
        while (dut.state_q !== ST_IDLE && cyc < 40) begin
            check("dbg_ready_held_off", 32'(dbg_ready), 32'd0);
            tick();
            cyc++;
        end
        check("dbg_ready_at_idle_entry", 32'(dbg_ready), 32'd1);
        check("cpu_ready_at_idle_entry", 32'(cpu_ready), 32'd0);
        exp_q.push_back({1'b1, 8'h3C});
        exp_last = 1;
        tick();
        dbg_valid = 1'b0;
        wait_state(ST_IDLE, 40, n);

        // ---- timeout: busy never rises, then err_clr ----
        busy_delay = 0;
        cpu_data = 8'h0F; cpu_valid = 1'b1;
        #1;
        exp_q.push_back({1'b0, 8'h0F});
        exp_last = 0;
        tick();
        cpu_valid = 1'b0;
        tick();
        check("to_wait_busy_entry", 32'(dut.state_q), 32'(ST_WAIT_BUSY));
        repeat (15) tick();
        check("to_not_yet_err", 32'(err_timeout), 32'd0);
        check("to_not_yet_state", 32'(dut.state_q), 32'(ST_WAIT_BUSY));
        tick();
        check("to_err_set", 32'(err_timeout), 32'd1);
        check("to_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        tick();
        check("to_err_sticky", 32'(err_timeout), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_err_cleared", 32'(err_timeout), 32'd0);

        // ---- timeout with err_clr in the same cycle: set wins ----
        cpu_data = 8'hF0; cpu_valid = 1'b1;
        #1;
        exp_q.push_back({1'b0, 8'hF0});
        exp_last = 0;
        tick();
        cpu_valid = 1'b0;
        tick();
        repeat (15) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("set_wins_over_clr", 32'(err_timeout), 32'd1);
        tick();
        check("set_wins_sticky", 32'(err_timeout), 32'd1);

        // ---- reset in WAIT_DONE with busy high ----
        busy_delay = 2; busy_len = 1000;
        cpu_data = 8'h99; cpu_valid = 1'b1;
        #1;
        exp_q.push_back({1'b0, 8'h99});
        exp_last = 0;
        tick();
        cpu_valid = 1'b0;
        wait_state(ST_WAIT_DONE, 20, n);
        check("f_reach_wait_done", 32'(dut.state_q), 32'(ST_WAIT_DONE));
        check("f_busy_high", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_state",    32'(dut.state_q), 32'(ST_IDLE));
        check("mid_rst_tx_start", 32'(tx_start), 32'd0);
        check("mid_rst_tx_data",  32'(tx_data), 32'h00);
        check("mid_rst_grant_id", 32'(grant_id), 32'd0);
        check("mid_rst_err",      32'(err_timeout), 32'd0);
        exp_last = 1;
        busy_kill = 1'b1;
        tick();
        busy_kill = 1'b0;
        busy_len = 3;
        repeat (3) tick();
        check("no_start_after_reset", 32'(tx_start), 32'd0);
        cpu_data = 8'hC3; dbg_data = 8'hD4;
        cpu_valid = 1'b1; dbg_valid = 1'b1;
        #1;
        winner = (exp_last == 1) ? 0 : 1;
        check("post_rst_cpu_wins", 32'(cpu_ready), 32'(winner == 0));
        check("post_rst_dbg_loses", 32'(dbg_ready), 32'(winner == 1));
        exp_q.push_back({1'b0, 8'hC3});
        exp_last = winner;
        tick();
        cpu_valid = 1'b0; dbg_valid = 1'b0;
        wait_state(ST_IDLE, 40, n);
        check("post_rst_idle", 32'(dut.state_q), 32'(ST_IDLE));

        repeat (2) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("tx_start_total", 32'(n_start), 32'd11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter WAIT_TO, default 16: max cycles after tx_start for tx_busy to rise.
REQ-002 SHALL have port sysclk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cpu_valid  input  1  CPU byte request.
REQ-005 SHALL have port cpu_data  input  8  CPU byte.
REQ-006 SHALL have port cpu_ready  output  1  CPU byte accepted this cycle.
REQ-007 SHALL have port dbg_valid  input  1  debug-port byte request.
REQ-008 SHALL have port dbg_data  input  8  debug-port byte.
REQ-009 SHALL have port dbg_ready  output  1  debug byte accepted this cycle.
REQ-010 SHALL have port tx_start  output  1  one-cycle launch pulse to UART transmitter.
REQ-011 SHALL have port tx_data  output  8  registered byte to transmitter, stable from tx_start until return to IDLE.
REQ-012 SHALL have port tx_busy  input  1  transmitter busy, from the baud-rate-timed serializer.
REQ-013 SHALL have port grant_id  output  1  owner of current/last transfer (0 = CPU, 1 = debug).
REQ-014 SHALL have port err_timeout  output  1  sticky timeout flag.
REQ-015 SHALL have port err_clr  input  1  clears err_timeout.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-017 In IDLE with any valid high, SHALL accept exactly one requester: cpu_ready/dbg_ready combinational, high only in IDLE, at most one per cycle.
REQ-018 Arbitration SHALL be round-robin: sole valid requester wins; both valid -> requester not served last wins.
REQ-019 Last-served pointer SHALL update on acceptance; reset value = debug, so CPU wins first contention.
REQ-020 On acceptance SHALL latch selected data into tx_data, set grant_id, go to START.
REQ-021 START SHALL assert tx_start for exactly one cycle, clear wait counter, go to WAIT_BUSY.
REQ-022 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; else counter increments; counter reaching WAIT_TO-1 with tx_busy=0 -> set err_timeout, go IDLE.
REQ-023 WAIT_DONE: tx_busy=0 -> IDLE; otherwise stay, no limit.
REQ-024 Minimum spacing between acceptances SHALL be 4 cycles (IDLE, START, WAIT_BUSY, WAIT_DONE).
REQ-025 Requester valid/data SHALL be ignored outside IDLE; requesters hold valid until ready.
REQ-026 err_timeout: set has priority over err_clr in the same cycle; otherwise err_clr clears it.
REQ-027 Wait counter width SHALL be $clog2(WAIT_TO)+1, saturating, no wrap.
REQ-028 tx_busy already high in START SHALL not be sampled; WAIT_BUSY sees it next cycle and advances.

Reset
REQ-029 reset SHALL force state IDLE, tx_start 0, tx_data 0, grant_id 0, err_timeout 0, counter 0, pointer debug.
REQ-030 reset mid-transfer SHALL abandon the accepted byte; no tx_start after reset deasserts unless a new acceptance occurs.
REQ-031 cpu_ready and dbg_ready SHALL be 0 during any cycle reset is high.

Structure
REQ-032 Shared package uart_pkg SHALL hold state encoding, requester IDs (REQ_CPU=0, REQ_DBG=1), WAIT_TO default, and baud/sample divider constants (5199, 324).
REQ-033 Round-robin selection SHALL be a sub-module rr_arb2 (2 requests, last pointer in, one-hot grant out); FSM, counter, data register stay in uart_tx_arbiter.

Verification
REQ-034 CPU alone sends 0x55, tx_busy rises 2 cycles after tx_start, held 10 cycles -> cpu_ready 1 cycle, tx_start 1 cycle later, tx_data=0x55, grant_id=0, IDLE after tx_busy falls.
REQ-035 Both valid continuously, cpu 0xA1, dbg 0xB2 -> grant order CPU, DBG, CPU, DBG; tx_data alternates 0xA1/0xB2; never both readys high.
REQ-036 tx_busy held 0 after tx_start, WAIT_TO=16 -> err_timeout=1 16 cycles after WAIT_BUSY entry, FSM IDLE; err_clr pulse -> 0.
REQ-037 err_clr asserted in timeout cycle -> err_timeout=1 (set wins).
REQ-038 reset pulsed in WAIT_DONE with tx_busy=1 -> next cycle all outputs at reset values, no tx_start, CPU wins next contention.
REQ-039 dbg_valid rises during WAIT_DONE -> dbg_ready stays 0 until IDLE, then asserts same cycle as IDLE entry.
